// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the keyboard front end of the game.
//   kbd_state_t      - scancode decoder FSM state
//   SC_*             - PS/2 Set-2 prefix and protocol byte values
//   JERRY_* / TOM_*  - per-player key assignments (make code + E0-extended flag)
//   RESET_KEY_*      - shared game-reset key (R)
//   is_protocol_byte - bytes that abort any sequence and drop all held keys
//   is_error_byte    - subset of protocol bytes that indicate a fault
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    EXT       = 2'b01,
    BREAK     = 2'b10,
    EXT_BREAK = 2'b11
  } kbd_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ERR   = 8'hFC;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_OVR   = 8'h00;

  // Jerry: arrow keys, all E0-extended.
  localparam logic [7:0] JERRY_LEFT_CODE  = 8'h6B;
  localparam bit         JERRY_LEFT_EXT   = 1'b1;
  localparam logic [7:0] JERRY_RIGHT_CODE = 8'h74;
  localparam bit         JERRY_RIGHT_EXT  = 1'b1;
  localparam logic [7:0] JERRY_JUMP_CODE  = 8'h75;
  localparam bit         JERRY_JUMP_EXT   = 1'b1;

  // Tom: A / D / W, plain codes.
  localparam logic [7:0] TOM_LEFT_CODE    = 8'h1C;
  localparam bit         TOM_LEFT_EXT     = 1'b0;
  localparam logic [7:0] TOM_RIGHT_CODE   = 8'h23;
  localparam bit         TOM_RIGHT_EXT    = 1'b0;
  localparam logic [7:0] TOM_JUMP_CODE    = 8'h1D;
  localparam bit         TOM_JUMP_EXT     = 1'b0;

  // Game reset: R.
  localparam logic [7:0] RESET_KEY_CODE   = 8'h2D;
  localparam bit         RESET_KEY_EXT    = 1'b0;

  // Keyboard housekeeping bytes: they can arrive in the middle of a sequence
  // and mean the keyboard lost or restarted its state.
  function automatic logic is_protocol_byte(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ERR) || (b == SC_ACK) || (b == SC_OVR);
  endfunction

  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == SC_ERR) || (b == SC_OVR);
  endfunction

endpackage

// File: rtl/keyboard_player_ctrl.sv
// -----------------------------------------------------------------------------
// keyboard_player_ctrl
// Turns the PS/2 Set-2 byte stream into held-key levels for one player plus a
// game-reset pulse. One instance per player; keys are chosen by parameter.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   key_byte   in   [7:0] scancode byte from the PS/2 receiver
//   key_valid  in   one-cycle strobe, key_byte valid when high
//   left       out  left key held
//   right      out  right key held
//   jump       out  jump key held
//   game_reset out  one-cycle pulse on every reset-key make (incl. repeats)
//   frame_err  out  one-cycle pulse on prefix timeout, FC or 00 byte
//
// All outputs are registered and change on the edge after the final byte of a
// sequence is strobed in.
// -----------------------------------------------------------------------------
module keyboard_player_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] LEFT_CODE      = JERRY_LEFT_CODE,
  parameter bit         LEFT_EXT       = JERRY_LEFT_EXT,
  parameter logic [7:0] RIGHT_CODE     = JERRY_RIGHT_CODE,
  parameter bit         RIGHT_EXT      = JERRY_RIGHT_EXT,
  parameter logic [7:0] JUMP_CODE      = JERRY_JUMP_CODE,
  parameter bit         JUMP_EXT       = JERRY_JUMP_EXT,
  parameter logic [7:0] RESET_CODE     = RESET_KEY_CODE,
  parameter bit         RESET_EXT      = RESET_KEY_EXT,
  parameter int         PREFIX_TIMEOUT = 65_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_byte,
  input  logic       key_valid,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       game_reset,
  output logic       frame_err
);

  // The timer is compared against the last count before expiry so the
  // timeout fires on the PREFIX_TIMEOUT-th idle cycle after the prefix.
  localparam logic [16:0] TIMEOUT_LAST = 17'(PREFIX_TIMEOUT - 1);

  kbd_state_t  state;
  logic [16:0] timer;

  logic byte_ext;
  logic is_proto;
  logic do_make;
  logic do_break;
  logic hit_left;
  logic hit_right;
  logic hit_jump;
  logic hit_reset;

  function automatic logic key_match(input logic [7:0] code,
                                     input logic       ext,
                                     input logic [7:0] key_code,
                                     input logic       key_ext);
    return (code == key_code) && (ext == key_ext);
  endfunction

  // Decode of the current byte in the context of the current state. A make
  // ends a sequence from IDLE or EXT unless the byte is itself a prefix that
  // the state accepts; any byte after a break prefix is the broken key.
  always_comb begin
    // NOTE: every signal driven here is assigned on every pass, so no storage
    // (latch) is implied.
    byte_ext  = (state == EXT) || (state == EXT_BREAK);
    is_proto  = is_protocol_byte(key_byte);
    do_make   = 1'b0;
    do_break  = 1'b0;
    if (key_valid && !is_proto) begin
      unique case (state)
        IDLE:            do_make  = (key_byte != SC_EXT) && (key_byte != SC_BREAK);
        EXT:             do_make  = (key_byte != SC_BREAK);
        BREAK, EXT_BREAK: do_break = 1'b1;
      endcase
    end
    hit_left  = key_match(key_byte, byte_ext, LEFT_CODE,  LEFT_EXT);
    hit_right = key_match(key_byte, byte_ext, RIGHT_CODE, RIGHT_EXT);
    hit_jump  = key_match(key_byte, byte_ext, JUMP_CODE,  JUMP_EXT);
    hit_reset = key_match(key_byte, byte_ext, RESET_CODE, RESET_EXT);
  end

  // Single FSM block: state, prefix timer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      left       <= 1'b0;
      right      <= 1'b0;
      jump       <= 1'b0;
      game_reset <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in the
      // same pass overrides these defaults, which makes the pulses one cycle.
      game_reset <= 1'b0;
      frame_err  <= 1'b0;

      if (key_valid) begin
        timer <= '0;
        if (is_proto) begin
          // Keyboard reset/ack/error: whatever was held is no longer known.
          state     <= IDLE;
          left      <= 1'b0;
          right     <= 1'b0;
          jump      <= 1'b0;
          frame_err <= is_error_byte(key_byte);
        end else begin
          unique case (state)
            IDLE: begin
              if (key_byte == SC_EXT)        state <= EXT;
              else if (key_byte == SC_BREAK) state <= BREAK;
              else                           state <= IDLE;
            end
            EXT: begin
              if (key_byte == SC_BREAK) state <= EXT_BREAK;
              else                      state <= IDLE;
            end
            BREAK, EXT_BREAK: state <= IDLE;
          endcase

          // Auto-repeat makes simply re-set a level that is already high.
          if (do_make) begin
            if (hit_left)  left       <= 1'b1;
            if (hit_right) right      <= 1'b1;
            if (hit_jump)  jump       <= 1'b1;
            if (hit_reset) game_reset <= 1'b1;
          end else if (do_break) begin
            if (hit_left)  left  <= 1'b0;
            if (hit_right) right <= 1'b0;
            if (hit_jump)  jump  <= 1'b0;
          end
        end
      end else if (state != IDLE) begin
        // A dangling prefix is dropped after the timeout; held levels stay,
        // since the keyboard may simply have lost the tail of a sequence.
        if (timer == TIMEOUT_LAST) begin
          state     <= IDLE;
          timer     <= '0;
          frame_err <= 1'b1;
        end else begin
          timer <= timer + 17'd1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keyboard_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keyboard_player_ctrl
// Directed bench for keyboard_player_ctrl with Jerry's default key set. A
// sequence-level model (pending prefix bytes kept in a queue) predicts every
// output each cycle; literal checks after each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_keyboard_player_ctrl;

  localparam int         TIMEOUT  = 65_000;
  localparam logic [7:0] RST_CODE = 8'h2D;
  localparam bit         RST_EXT  = 1'b0;

  logic       clk;
  logic       rst;
  logic [7:0] key_byte;
  logic       key_valid;
  logic       left;
  logic       right;
  logic       jump;
  logic       game_reset;
  logic       frame_err;

  keyboard_player_ctrl #(
    .LEFT_CODE      (8'h6B),
    .LEFT_EXT       (1'b1),
    .RIGHT_CODE     (8'h74),
    .RIGHT_EXT      (1'b1),
    .JUMP_CODE      (8'h75),
    .JUMP_EXT       (1'b1),
    .RESET_CODE     (RST_CODE),
    .RESET_EXT      (RST_EXT),
    .PREFIX_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_byte   (key_byte),
    .key_valid  (key_valid),
    .left       (left),
    .right      (right),
    .jump       (jump),
    .game_reset (game_reset),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int gr_count = 0;
  int fe_count = 0;

  task automatic check(input string name, input bit act, input bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: bytes of an unfinished sequence wait in a queue; when the closing
  // byte arrives the queue says whether it was extended and/or a break.
  // ---------------------------------------------------------------------------
  logic [7:0] kc [3] = '{8'h6B, 8'h74, 8'h75};
  bit         ke [3] = '{1'b1, 1'b1, 1'b1};
  bit         m_held [3];
  bit         m_gr;
  bit         m_fe;
  logic [7:0] seq [$];
  longint     cyc;
  longint     last_cyc;

  initial begin
    m_held = '{1'b0, 1'b0, 1'b0};
    m_gr = 1'b0;
    m_fe = 1'b0;
    cyc = 0;
    last_cyc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_held = '{1'b0, 1'b0, 1'b0};
        m_gr = 1'b0;
        m_fe = 1'b0;
        seq.delete();
      end else begin
        cyc++;
        m_gr = 1'b0;
        m_fe = 1'b0;
        if (key_valid) begin
          if (key_byte inside {8'hAA, 8'hFC, 8'hFA, 8'h00}) begin
            m_held = '{1'b0, 1'b0, 1'b0};
            seq.delete();
            m_fe = (key_byte == 8'hFC) || (key_byte == 8'h00);
          end else if ((seq.size() == 0 && (key_byte == 8'hE0 || key_byte == 8'hF0)) ||
                       (seq.size() == 1 && seq[0] == 8'hE0 && key_byte == 8'hF0)) begin
            seq.push_back(key_byte);
            last_cyc = cyc;
          end else begin
            bit is_ext;
            bit is_brk;
            is_ext = 1'b0;
            is_brk = 1'b0;
            foreach (seq[i]) begin
              if (seq[i] == 8'hE0) is_ext = 1'b1;
              if (seq[i] == 8'hF0) is_brk = 1'b1;
            end
            for (int k = 0; k < 3; k++)
              if (key_byte == kc[k] && is_ext == ke[k]) m_held[k] = !is_brk;
            if (!is_brk && key_byte == RST_CODE && is_ext == RST_EXT) m_gr = 1'b1;
            seq.delete();
          end
        end else if (seq.size() != 0 && (cyc - last_cyc) == longint'(TIMEOUT)) begin
          seq.delete();
          m_fe = 1'b1;
        end
      end
    end
  end

  // Single compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cyc left",       left,       m_held[0]);
        check("cyc right",      right,      m_held[1]);
        check("cyc jump",       jump,       m_held[2]);
        check("cyc game_reset", game_reset, m_gr);
        check("cyc frame_err",  frame_err,  m_fe);
        if (game_reset) gr_count++;
        if (frame_err)  fe_count++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [7:0] b);
    @(posedge clk);
    #2;
    key_byte  = b;
    key_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      key_valid = 1'b0;
    end
  endtask

  // One strobed byte; returns just after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    drive(b);
    idle(1);
  endtask

  int gr0;
  int fe0;

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset left",       left,       1'b0);
    check("reset right",      right,      1'b0);
    check("reset jump",       jump,       1'b0);
    check("reset game_reset", game_reset, 1'b0);
    check("reset frame_err",  frame_err,  1'b0);

    // 1: extended make/break of left
    send(8'hE0);
    send(8'h6B);
    check("t1 left make", left, 1'b1);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("t1 left break", left, 1'b0);
    check("t1 right idle", right, 1'b0);
    check("t1 jump idle", jump, 1'b0);

    // 2: extended flag must match; reset key pulses only on make
    send(8'h6B);
    check("t2 plain 6B ignored", left, 1'b0);
    gr0 = gr_count;
    send(8'h2D);
    check("t2 reset pulse high", game_reset, 1'b1);
    idle(1);
    check("t2 reset pulse low", game_reset, 1'b0);
    check_n("t2 reset pulse count", gr_count - gr0, 1);
    gr0 = gr_count;
    send(8'hF0);
    send(8'h2D);
    idle(2);
    check_n("t2 reset break no pulse", gr_count - gr0, 0);

    // 3: hold right and jump, back-to-back auto-repeat, release jump only
    send(8'hE0);
    send(8'h74);
    send(8'hE0);
    send(8'h75);
    check("t3 right held", right, 1'b1);
    check("t3 jump held", jump, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(8'hE0);
      drive(8'h74);
    end
    idle(1);
    check("t3 right after repeat", right, 1'b1);
    check("t3 jump after repeat", jump, 1'b1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("t3 jump released", jump, 1'b0);
    check("t3 right still held", right, 1'b1);

    // 4: prefix timeout after exactly TIMEOUT idle cycles
    fe0 = fe_count;
    send(8'hE0);
    idle(TIMEOUT - 1);
    check("t4 no frame_err before timeout", frame_err, 1'b0);
    idle(1);
    check("t4 frame_err at timeout", frame_err, 1'b1);
    idle(1);
    check("t4 frame_err one cycle", frame_err, 1'b0);
    check_n("t4 frame_err count", fe_count - fe0, 1);
    send(8'h75);
    check("t4 plain 75 ignored", jump, 1'b0);
    check("t4 right kept over timeout", right, 1'b1);

    // 5: protocol bytes drop all levels
    send(8'hE0);
    send(8'h6B);
    check("t5 left held", left, 1'b1);
    check("t5 right held", right, 1'b1);
    send(8'hAA);
    check("t5 AA left", left, 1'b0);
    check("t5 AA right", right, 1'b0);
    check("t5 AA no frame_err", frame_err, 1'b0);
    send(8'hE0);
    send(8'h6B);
    send(8'hE0);
    send(8'h74);
    send(8'hFC);
    check("t5 FC left", left, 1'b0);
    check("t5 FC right", right, 1'b0);
    check("t5 FC frame_err", frame_err, 1'b1);
    idle(1);
    check("t5 FC frame_err one cycle", frame_err, 1'b0);
    send(8'hE0);
    send(8'h6B);
    send(8'hF0);
    send(8'h00);
    check("t5 00 in break left", left, 1'b0);
    check("t5 00 frame_err", frame_err, 1'b1);

    // 6: reset mid-sequence clears outputs asynchronously and drops prefix
    send(8'hE0);
    send(8'h6B);
    check("t6 left held", left, 1'b1);
    send(8'hE0);
    #1;
    rst = 1'b1;
    #1;
    check("t6 async left",       left,       1'b0);
    check("t6 async right",      right,      1'b0);
    check("t6 async jump",       jump,       1'b0);
    check("t6 async game_reset", game_reset, 1'b0);
    check("t6 async frame_err",  frame_err,  1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    send(8'h74);
    check("t6 plain 74 after reset", right, 1'b0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
